// File: rtl/weight_bank.sv
// ---------------------------------------------------------------------------
// weight_bank
//
// Holds one convolution weight set: KERNEL_COUNT kernel words, BIAS_COUNT
// bias words and a single MACC coefficient in the last address. Words arrive
// over a flat write interface and are served to the conv engine through a
// registered kernel read port plus continuous bias/coefficient views.
//
// Optional feature macro: WEIGHT_BANK_DOUBLE_BUF_EN
//   defined   : two banks. New sets load into the staging bank while the
//               engine reads the active bank; a swap handshake exchanges them.
//   undefined : one live bank. Writes land directly in it, and a swap only
//               acknowledges and rearms load_done.
//
// WEIGHT_COUNT must equal KERNEL_COUNT + BIAS_COUNT + 1.
//
// Ports
//   clk             : clock, rising edge
//   rst_n           : asynchronous active-low reset
//   weight_wr_data  : word to store
//   weight_wr_addr  : flat word address
//   weight_wr_en    : one-cycle write strobe
//   kernel_rd_en    : kernel read request
//   kernel_rd_addr  : kernel index
//   kernel_rd_data  : registered kernel word from the active bank
//   kernel_rd_valid : high the cycle kernel_rd_data answers a request
//   bias_data       : active-bank biases, bias 0 in bits [31:0]
//   macc_coeff      : active-bank MACC coefficient
//   swap_req        : level request from the engine for the staged set
//   swap_ack        : one-cycle pulse when a swap takes effect
//   load_done       : every staging address written since last swap/reset
//   weights_ready   : the active bank holds a complete set
//   addr_err        : sticky out-of-range write flag
// ---------------------------------------------------------------------------
module weight_bank #(
  parameter int KERNEL_COUNT = 72,
  parameter int BIAS_COUNT   = 4,
  parameter int WEIGHT_COUNT = 77
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [31:0]              weight_wr_data,
  input  logic [31:0]              weight_wr_addr,
  input  logic                     weight_wr_en,
  input  logic                     kernel_rd_en,
  input  logic [6:0]               kernel_rd_addr,
  output logic [31:0]              kernel_rd_data,
  output logic                     kernel_rd_valid,
  output logic [BIAS_COUNT*32-1:0] bias_data,
  output logic [31:0]              macc_coeff,
  input  logic                     swap_req,
  output logic                     swap_ack,
  output logic                     load_done,
  output logic                     weights_ready,
  output logic                     addr_err
);

  localparam int ADDR_W = $clog2(WEIGHT_COUNT);
  localparam logic [31:0] WEIGHT_LIMIT = 32'(WEIGHT_COUNT);
  localparam logic [6:0]  KERNEL_LIMIT = 7'(KERNEL_COUNT);

  logic [WEIGHT_COUNT-1:0] wr_mask;
  logic [WEIGHT_COUNT-1:0] mask_next;
  logic [ADDR_W-1:0]       wr_idx;
  logic [ADDR_W-1:0]       rd_idx;
  logic                    wr_in_range;
  logic                    wr_accept;
  logic                    rd_in_range;
  logic                    swap_fire;
  logic [31:0]             active_view [WEIGHT_COUNT];

  assign wr_idx      = weight_wr_addr[ADDR_W-1:0];
  assign rd_idx      = ADDR_W'(kernel_rd_addr);
  assign wr_in_range = (weight_wr_addr < WEIGHT_LIMIT);
  assign wr_accept   = weight_wr_en && wr_in_range;
  assign rd_in_range = (kernel_rd_addr < KERNEL_LIMIT);

  // A write in the same cycle as a pending swap wins; the swap waits for the
  // first write-free cycle, so the colliding word lands in the pre-swap
  // staging bank and is carried across by the swap.
  assign swap_fire = swap_req && load_done && !weight_wr_en;

`ifdef WEIGHT_BANK_DOUBLE_BUF_EN

  logic [31:0] bank0 [WEIGHT_COUNT];
  logic [31:0] bank1 [WEIGHT_COUNT];
  logic        bank_sel;

  // Writes only ever touch the staging bank, i.e. the one not selected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WEIGHT_COUNT; i++) begin
        bank0[i] <= '0;
        bank1[i] <= '0;
      end
    end else if (wr_accept) begin
      if (bank_sel) begin
        bank0[wr_idx] <= weight_wr_data;
      end else begin
        bank1[wr_idx] <= weight_wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_sel <= 1'b0;
    end else if (swap_fire) begin
      bank_sel <= ~bank_sel;
    end
  end

  always_comb begin
    for (int i = 0; i < WEIGHT_COUNT; i++) begin
      active_view[i] = bank_sel ? bank1[i] : bank0[i];
    end
  end

  // Ready means a complete set has been swapped in at least once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weights_ready <= 1'b0;
    end else if (swap_fire) begin
      weights_ready <= 1'b1;
    end
  end

`else

  logic [31:0] bank0 [WEIGHT_COUNT];

  // Single live bank: writes are immediately visible to the engine.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WEIGHT_COUNT; i++) begin
        bank0[i] <= '0;
      end
    end else if (wr_accept) begin
      bank0[wr_idx] <= weight_wr_data;
    end
  end

  always_comb begin
    for (int i = 0; i < WEIGHT_COUNT; i++) begin
      active_view[i] = bank0[i];
    end
  end

  // Ready rises together with the first load_done and stays until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weights_ready <= 1'b0;
    end else if (&mask_next) begin
      weights_ready <= 1'b1;
    end
  end

`endif

  // Write-completion mask for the staging set. A swap and an accepted write
  // can never share a cycle, so clearing has no conflict with setting.
  always_comb begin
    mask_next = wr_mask;
    if (swap_fire) begin
      mask_next = '0;
    end else if (wr_accept) begin
      mask_next[wr_idx] = 1'b1;
    end
  end

  // load_done is computed from the next mask so it is high in the cycle
  // right after the completing write and drops on the swap edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_mask   <= '0;
      load_done <= 1'b0;
    end else begin
      wr_mask   <= mask_next;
      load_done <= &mask_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      swap_ack <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      swap_ack <= swap_fire;
      if (weight_wr_en && !wr_in_range) begin
        addr_err <= 1'b1;
      end
    end
  end

  // Registered read of the bank that is active during the request cycle, so
  // a read in the swap cycle still sees the old set. Data holds when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kernel_rd_data  <= '0;
      kernel_rd_valid <= 1'b0;
    end else begin
      kernel_rd_valid <= kernel_rd_en;
      if (kernel_rd_en) begin
        kernel_rd_data <= rd_in_range ? active_view[rd_idx] : 32'h0;
      end
    end
  end

  for (genvar b = 0; b < BIAS_COUNT; b++) begin : g_bias
    assign bias_data[b*32 +: 32] = active_view[KERNEL_COUNT + b];
  end

  assign macc_coeff = active_view[WEIGHT_COUNT - 1];

endmodule
